// File: rtl/serial_cpu_8bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_cpu_8bit
// Description : Multi-cycle CPU core running a 16-bit ISA over an 8-bit
//               memory bus. Each instruction is fetched as two bytes
//               (little-endian) and executed one at a time. LOAD/STORE
//               move 16-bit data as two byte transfers.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous reset, active-high
//               enable     - 0 freezes the FSM, registers and outputs
//               start      - launch pulse, honoured in IDLE/HALT
//               i_datain   - instruction byte from memory
//               d_datain   - data byte from memory
//               is_i_addr  - 1: i_addr owns memory, 0: d_addr owns memory
//               i_addr     - instruction byte address {pc, byte_sel}
//               d_addr     - data byte address {ea, byte_sel}
//               d_we       - memory write strobe (data phase only)
//               d_dataout  - byte to write
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cpu_8bit #(
    parameter logic [7:0] DEFAULT_PC_ADDR = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] i_datain,
    input  logic [7:0] d_datain,
    output logic       is_i_addr,
    output logic [8:0] i_addr,
    output logic [8:0] d_addr,
    output logic       d_we,
    output logic [7:0] d_dataout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_L = 3'd1;
    localparam logic [2:0] S_FETCH_H = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_MEM_L   = 3'd4;
    localparam logic [2:0] S_MEM_H   = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;

    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_SET   = 5'b10011;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    logic [2:0]  r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_gr [8];
    logic        r_zf;
    logic        r_nf;
    logic        r_cf;
    logic [7:0]  r_ld_lo;

    // Instruction fields
    logic [4:0]  w_op;
    logic [2:0]  w_r1;
    logic [2:0]  w_r2;
    logic [2:0]  w_r3;
    logic [7:0]  w_imm;
    logic [3:0]  w_val;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_c;
    logic [7:0]  w_ea;
    logic        w_sel;
    logic        w_mem;

    assign w_op  = r_ir[15:11];
    assign w_r1  = r_ir[10:8];
    assign w_r2  = r_ir[6:4];
    assign w_r3  = r_ir[2:0];
    assign w_imm = r_ir[7:0];
    assign w_val = r_ir[3:0];
    // gr0 is never written, so it reads as zero without a special case
    assign w_a   = r_gr[w_r1];
    assign w_b   = r_gr[w_r2];
    assign w_c   = r_gr[w_r3];
    assign w_ea  = w_b[7:0] + {4'd0, w_val};

    // Byte select is the high half of whichever 16-bit transfer is active
    assign w_sel = (r_state == S_FETCH_H) || (r_state == S_MEM_H);
    assign w_mem = (r_state == S_MEM_L) || (r_state == S_MEM_H);

    // Outputs decode straight from held state, so they freeze with enable
    assign is_i_addr = ~w_mem;
    assign i_addr    = {r_pc, w_sel};
    assign d_addr    = {w_ea, w_sel};
    assign d_we      = w_mem && (w_op == OP_STORE);
    assign d_dataout = !d_we ? 8'h00 : (w_sel ? w_a[15:8] : w_a[7:0]);

    // Execute-stage datapath
    logic [16:0] w_sum;
    logic [15:0] w_res;
    logic        w_cout;
    logic        w_wr;
    logic        w_fl;
    logic        w_jmp;
    logic [7:0]  w_tgt;

    always_comb begin
        w_sum  = 17'd0;
        w_res  = 16'd0;
        w_cout = 1'b0;
        w_wr   = 1'b0;
        w_fl   = 1'b0;
        w_jmp  = 1'b0;
        w_tgt  = w_a[7:0] + w_imm;
        case (w_op)
            OP_SLL, OP_SLA: begin w_res = w_b << w_val; w_wr = 1'b1; w_fl = 1'b1; end
            OP_SRL:  begin w_res = w_b >> w_val; w_wr = 1'b1; w_fl = 1'b1; end
            OP_SRA:  begin w_res = $signed(w_b) >>> w_val; w_wr = 1'b1; w_fl = 1'b1; end
            OP_AND:  begin w_res = w_b & w_c; w_wr = 1'b1; w_fl = 1'b1; end
            OP_OR:   begin w_res = w_b | w_c; w_wr = 1'b1; w_fl = 1'b1; end
            OP_XOR:  begin w_res = w_b ^ w_c; w_wr = 1'b1; w_fl = 1'b1; end
            // Subtractions in 17 bits leave the borrow in bit 16
            OP_ADD:  begin w_sum = {1'b0, w_b} + {1'b0, w_c}; w_wr = 1'b1; w_fl = 1'b1; end
            OP_ADDI: begin w_sum = {1'b0, w_a} + {9'd0, w_imm}; w_wr = 1'b1; w_fl = 1'b1; end
            OP_SUB:  begin w_sum = {1'b0, w_b} - {1'b0, w_c}; w_wr = 1'b1; w_fl = 1'b1; end
            OP_SUBI: begin w_sum = {1'b0, w_a} - {9'd0, w_imm}; w_wr = 1'b1; w_fl = 1'b1; end
            OP_CMP:  begin w_sum = {1'b0, w_b} - {1'b0, w_c}; w_fl = 1'b1; end
            OP_LDIH: begin w_sum = {1'b0, w_a} + {1'b0, w_imm, 8'h00}; w_wr = 1'b1; w_fl = 1'b1; end
            OP_ADDC: begin w_sum = {1'b0, w_b} + {1'b0, w_c} + {16'd0, r_cf}; w_wr = 1'b1; w_fl = 1'b1; end
            OP_SUBC: begin w_sum = {1'b0, w_b} - {1'b0, w_c} - {16'd0, r_cf}; w_wr = 1'b1; w_fl = 1'b1; end
            OP_SET:  begin w_res = {8'h00, w_imm}; w_wr = 1'b1; end
            OP_JUMP: begin w_jmp = 1'b1; w_tgt = w_imm; end
            OP_JMPR: w_jmp = 1'b1;
            OP_BZ:   w_jmp = r_zf;
            OP_BNZ:  w_jmp = ~r_zf;
            OP_BN:   w_jmp = r_nf;
            OP_BNN:  w_jmp = ~r_nf;
            OP_BC:   w_jmp = r_cf;
            OP_BNC:  w_jmp = ~r_cf;
            default: ;
        endcase
        if (w_op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_CMP, OP_LDIH, OP_ADDC, OP_SUBC}) begin
            w_res  = w_sum[15:0];
            w_cout = w_sum[16];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= 8'd0;
            r_ir    <= 16'd0;
            r_zf    <= 1'b0;
            r_nf    <= 1'b0;
            r_cf    <= 1'b0;
            r_ld_lo <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_gr[i] <= 16'd0;
            end
        end else if (enable) begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc    <= DEFAULT_PC_ADDR;
                        r_state <= S_FETCH_L;
                    end
                end
                S_FETCH_L: begin
                    r_ir[7:0] <= i_datain;
                    r_state   <= S_FETCH_H;
                end
                S_FETCH_H: begin
                    r_ir[15:8] <= i_datain;
                    r_state    <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_op == OP_LOAD || w_op == OP_STORE) begin
                        r_state <= S_MEM_L;
                    end else begin
                        if (w_wr && w_r1 != 3'd0) begin
                            r_gr[w_r1] <= w_res;
                        end
                        if (w_fl) begin
                            r_zf <= (w_res == 16'd0);
                            r_nf <= w_res[15];
                            r_cf <= w_cout;
                        end
                        r_pc    <= w_jmp ? w_tgt : r_pc + 8'd1;
                        r_state <= S_FETCH_L;
                    end
                end
                S_MEM_L: begin
                    r_ld_lo <= d_datain;
                    r_state <= S_MEM_H;
                end
                S_MEM_H: begin
                    if (w_op == OP_LOAD && w_r1 != 3'd0) begin
                        r_gr[w_r1] <= {d_datain, r_ld_lo};
                    end
                    r_pc    <= r_pc + 8'd1;
                    r_state <= S_FETCH_L;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_cpu_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_cpu_8bit
// Description : Self-checking bench for serial_cpu_8bit. A byte-wide memory
//               model sits on the muxed bus; an instruction-level reference
//               interpreter predicts every memory write (cycle, address,
//               data) into a scoreboard queue that a monitor drains, plus
//               final registers, flags, halt address and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_cpu_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       start;
    logic [7:0] i_datain;
    logic [7:0] d_datain;
    logic       is_i_addr;
    logic [8:0] i_addr;
    logic [8:0] d_addr;
    logic       d_we;
    logic [7:0] d_dataout;

    serial_cpu_8bit #(.DEFAULT_PC_ADDR(8'd16)) dut (
        .clk       (clk),
        .rst_n     (rst),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .d_datain  (d_datain),
        .is_i_addr (is_i_addr),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_dataout (d_dataout)
    );

    initial forever #5 clk = ~clk;

    // Byte-wide SRAM: combinational read, synchronous write; a bench loader
    // port takes priority so code/data can be placed while the core idles.
    logic [7:0] mem [512];
    logic       ld_we;
    logic [8:0] ld_a;
    logic [7:0] ld_d;
    assign i_datain = mem[i_addr];
    assign d_datain = mem[d_addr];
    always @(posedge clk) begin
        if (ld_we) mem[ld_a] <= ld_d;
        else if (d_we && !is_i_addr) mem[d_addr] <= d_dataout;
    end

    // Cycle index since the start edge, counting only enabled cycles
    int cnt = 0;
    always @(posedge clk) begin
        if (enable) cnt <= start ? 0 : cnt + 1;
    end

    logic [27:0] outs;
    assign outs = {is_i_addr, i_addr, d_addr, d_we, d_dataout};

    int n_chk  = 0;
    int n_pass = 0;
    int we_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int t; bit [8:0] a; bit [7:0] d; } wr_t;
    wr_t        sbq [$];
    bit [7:0]   mmem [512];
    bit [15:0]  mgr [8];
    bit         mz, mn, mc;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mgr[i] = 16'd0;
        mz = 0; mn = 0; mc = 0;
    endtask

    task automatic model_run(output int ht, output bit [7:0] hpc);
        bit [7:0] pc;
        int t;
        pc = 8'd16; t = 0; ht = 0; hpc = 0;
        for (int step = 0; step < 400; step++) begin
            bit [15:0] ins;
            int op, ra, x, y, z, imm, v, r, tgt;
            bit wr, fl, taken;
            bit [7:0] ea;
            ins = {mmem[{pc, 1'b1}], mmem[{pc, 1'b0}]};
            op = int'(ins[15:11]); ra = int'(ins[10:8]);
            x = int'(mgr[ra]); y = int'(mgr[ins[6:4]]); z = int'(mgr[ins[2:0]]);
            imm = int'(ins[7:0]); v = int'(ins[3:0]);
            ea = 8'(y + v);
            r = 0; wr = 0; fl = 0; taken = 0; tgt = x + imm;
            if (op == 1) begin ht = t + 3; hpc = pc; return; end
            if (op == 2 || op == 3) begin
                if (op == 2) begin
                    if (ra != 0) mgr[ra] = {mmem[{ea, 1'b1}], mmem[{ea, 1'b0}]};
                end else begin
                    sbq.push_back('{t + 3, {ea, 1'b0}, 8'(x)});
                    sbq.push_back('{t + 4, {ea, 1'b1}, 8'(x >> 8)});
                    mmem[{ea, 1'b0}] = 8'(x);
                    mmem[{ea, 1'b1}] = 8'(x >> 8);
                end
                pc = pc + 8'd1; t += 5;
                continue;
            end
            case (op)
                4, 5: begin r = (y << v) & 'hFFFF; wr = 1; fl = 1; end
                6:  begin r = y >> v; wr = 1; fl = 1; end
                7:  begin r = (((y >= 32768) ? y - 65536 : y) >>> v) & 'hFFFF; wr = 1; fl = 1; end
                8:  begin r = y + z; wr = 1; fl = 1; end
                9:  begin r = x + imm; wr = 1; fl = 1; end
                10: begin r = y - z; wr = 1; fl = 1; end
                11: begin r = x - imm; wr = 1; fl = 1; end
                12: begin r = y - z; fl = 1; end
                13: begin r = y & z; wr = 1; fl = 1; end
                14: begin r = y | z; wr = 1; fl = 1; end
                15: begin r = y ^ z; wr = 1; fl = 1; end
                16: begin r = x + imm * 256; wr = 1; fl = 1; end
                17: begin r = y + z + int'(mc); wr = 1; fl = 1; end
                18: begin r = y - z - int'(mc); wr = 1; fl = 1; end
                19: begin r = imm; wr = 1; end
                24: begin taken = 1; tgt = imm; end
                25: taken = 1;
                26: taken = mz;
                27: taken = !mz;
                28: taken = mn;
                29: taken = !mn;
                30: taken = mc;
                31: taken = !mc;
                default: ;
            endcase
            if (fl) begin
                mc = (r < 0) || (r > 65535);
                r = r & 'hFFFF;
                mz = (r == 0);
                mn = r[15];
            end
            if (wr && ra != 0) mgr[ra] = 16'(r);
            pc = taken ? 8'(tgt) : pc + 8'd1;
            t += 3;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial forever begin
        @(negedge clk);
        if (!rst && enable && d_we && !is_i_addr) begin
            we_cnt++;
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d", d_addr, d_dataout, cnt);
            end else begin
                wr_t e;
                e = sbq.pop_front();
                chk("write(cycle,addr,data)", {cnt[14:0], d_addr, d_dataout}, {e.t[14:0], e.a, e.d});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_byte(input int a, input bit [7:0] d);
        ld_a = 9'(a); ld_d = d; ld_we = 1'b1;
        mmem[a] = d;
        @(posedge clk); #1 ld_we = 1'b0;
    endtask

    task automatic put_word(input int w, input bit [15:0] ins);
        load_byte(2 * w, ins[7:0]);
        load_byte(2 * w + 1, ins[15:8]);
    endtask

    task automatic wait_cnt(input int target, input string nm);
        int g;
        g = 0;
        do begin @(negedge clk); g++; end while (cnt < target && g < 2000);
        if (cnt < target) begin
            n_chk++;
            $display("FAIL timeout_%s: cycle %0d required %0d", nm, cnt, target);
        end
    endtask

    task automatic wait_dwe(output bit ok);
        ok = 0;
        for (int g = 0; g < 400; g++) begin
            @(posedge clk); #1;
            if (d_we) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL timeout_d_we: d_we %0b required 1", d_we);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_prog(input bit freeze);
        int ht, diffs;
        bit [7:0] hpc;
        bit ok;
        logic [27:0] snap;
        we_cnt = 0;
        model_run(ht, hpc);
        pulse_start();
        if (freeze) begin
            wait_dwe(ok);
            snap = outs;
            enable = 1'b0;
            diffs = 0;
            repeat (10) begin
                @(negedge clk);
                if (outs !== snap) diffs++;
            end
            chk("freeze_outputs_changed", diffs, 0);
            @(posedge clk); #1 enable = 1'b1;
        end
        wait_cnt(ht - 2, "fetch_h");
        chk("halt_fetch_h_addr", {is_i_addr, i_addr}, {1'b1, hpc, 1'b1});
        wait_cnt(ht + 1, "halt");
        chk("halt_addr", {is_i_addr, i_addr}, {1'b1, hpc, 1'b0});
        wait_cnt(ht + 4, "halt_hold");
        chk("halt_addr_held", {is_i_addr, i_addr, d_we}, {1'b1, hpc, 1'b0, 1'b0});
        chk("scoreboard_pending", sbq.size(), 0);
        sbq.delete();
        for (int i = 1; i < 8; i++) chk($sformatf("gr%0d", i), dut.r_gr[i], mgr[i]);
        chk("flags_znc", {dut.r_zf, dut.r_nf, dut.r_cf}, {mz, mn, mc});
        diffs = 0;
        for (int a = 0; a < 32; a++) if (mem[a] !== mmem[a]) diffs++;
        chk("data_mem_bytes_differing", diffs, 0);
    endtask

    function automatic bit [15:0] rand_ins(input int w);
        bit [15:0] i;
        i = 16'($urandom);
        case ($urandom_range(0, 11))
            0, 1:    i[15:11] = 5'd19;
            2:       i[15:11] = 5'd16;
            3, 4, 5: i[15:11] = 5'($urandom_range(4, 18));
            6:       i = {5'd2, i[10:8], 4'd0, i[3:0]};
            7:       i = {5'd3, i[10:8], 4'd0, i[3:0]};
            8, 9:    i = {5'($urandom_range(26, 31)), 3'd0, 8'(w + 2)};
            10:      i = ($urandom_range(0, 1) == 0) ? {5'd24, 3'd0, 8'(w + 2)} : {5'd25, 3'd0, 8'(w + 1)};
            default: i[15:11] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(20, 23));
        endcase
        return i;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int ht;
        bit [7:0] hpc;
        bit ok;
        rst = 1'b1; enable = 1'b1; start = 1'b0; ld_we = 1'b0; ld_a = '0; ld_d = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {4'd0, outs}, {4'd0, 1'b1, 9'd0, 9'd0, 1'b0, 8'd0});
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {4'd0, outs}, {4'd0, 1'b1, 9'd0, 9'd0, 1'b0, 8'd0});

        for (int a = 0; a < 32; a++) load_byte(a, 8'($urandom));

        // Summation loop
        put_word(16, 16'h9B04); put_word(17, 16'h9900); put_word(18, 16'h4113);
        put_word(19, 16'h5B01); put_word(20, 16'hD812); put_word(21, 16'h1902);
        put_word(22, 16'h0800);
        run_prog(0);
        chk("loop_sum_lo", mem[4], 8'h0A);
        chk("loop_sum_hi", mem[5], 8'h00);
        chk("loop_zf", dut.r_zf, 1'b1);

        // LOAD then STORE through a register
        load_byte(0, 8'hAB); load_byte(1, 8'h00);
        put_word(16, 16'h1200); put_word(17, 16'h1A03); put_word(18, 16'h0800);
        run_prog(0);
        chk("copy_lo", mem[6], 8'hAB);
        chk("copy_hi", mem[7], 8'h00);
        chk("copy_we_cycles", we_cnt, 2);

        // Borrow out of zero
        put_word(16, 16'h9901); put_word(17, 16'h5201); put_word(18, 16'h0800);
        run_prog(0);
        chk("sub_gr2", dut.r_gr[2], 16'hFFFF);
        chk("sub_flags_znc", {dut.r_zf, dut.r_nf, dut.r_cf}, 3'b011);

        // SET then HALT: no writes, pc parked at 17
        put_word(16, 16'h9905); put_word(17, 16'h0800);
        run_prog(0);
        repeat (5) @(negedge clk);
        chk("set_halt_we_cycles", we_cnt, 0);
        chk("set_halt_pc17", i_addr, {8'd17, 1'b0});

        // Loop again with enable dropped during the STORE's first data cycle
        put_word(16, 16'h9B04); put_word(17, 16'h9900); put_word(18, 16'h4113);
        put_word(19, 16'h5B01); put_word(20, 16'hD812); put_word(21, 16'h1902);
        put_word(22, 16'h0800);
        load_byte(4, 8'h00); load_byte(5, 8'h00);
        run_prog(1);
        chk("freeze_sum_lo", mem[4], 8'h0A);
        chk("freeze_sum_hi", mem[5], 8'h00);

        // Reset while the STORE is driving the bus
        load_byte(4, 8'h00); load_byte(5, 8'h00);
        model_run(ht, hpc);
        pulse_start();
        wait_dwe(ok);
        #1 rst = 1'b1;
        #1 chk("midreset_outputs", {4'd0, outs}, {4'd0, 1'b1, 9'd0, 9'd0, 1'b0, 8'd0});
        sbq.delete();
        model_reset();
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        chk("midreset_write_cut_off", mem[4], 8'h00);
        load_byte(4, 8'h00); load_byte(5, 8'h00);
        run_prog(0);
        chk("rerun_sum_lo", mem[4], 8'h0A);

        // Randomized straight-line programs; registers dumped to words 8..14
        for (int p = 0; p < 20; p++) begin
            for (int w = 16; w < 30; w++) put_word(w, rand_ins(w));
            for (int i = 1; i < 8; i++) put_word(29 + i, {5'd3, 3'(i), 4'd0, 4'(7 + i)});
            put_word(37, 16'h0800);
            run_prog(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
